// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the uart_cfg core: parity modes, TX/RX
// state encodings and the oversampling mid-point used to centre RX sampling.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } par_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int OVERSAMPLING_DEFAULT = 16;

    function automatic int mid_point(input int oversampling);
        return oversampling / 2;
    endfunction

    localparam int MID_POINT_DEFAULT = mid_point(OVERSAMPLING_DEFAULT);

    // Encoding 2'b11 falls through to "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    function automatic logic par_bit(input logic [1:0] mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversampling tick generator: a down-counter reloaded from the divisor,
// pulsing once every div+1 clocks; a new divisor is picked up at reload.
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART (divisor, parity, stop bits) with RX error flags.
// Define UART_LOOPBACK_EN to add CFG_LOOP, routing the TX stream into RX.
module uart_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int DIV_W        = 16
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic [DIV_W-1:0]     CFG_DIV,
    input  logic [1:0]           CFG_PAR,
    input  logic                 CFG_STOP2,
    input  logic [DATA_BITS-1:0] TX_DI,
    input  logic                 TX_DRDY,
    output logic                 TX_BUSY,
    output logic                 TX_DONE,
    output logic                 TX_DSER,
    input  logic                 RX_DSER,
    output logic [DATA_BITS-1:0] RX_DO,
    output logic                 RX_DRDY,
    output logic                 RX_PERR,
    output logic                 RX_FERR
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                 CFG_LOOP
`endif
);
    import uart_pkg::*;

    localparam int OS_W = $clog2(OVERSAMPLING);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLING - 1);
    localparam logic [OS_W-1:0] MID_LAST  = OS_W'(mid_point(OVERSAMPLING) - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);

    logic tick;
    logic tx_ser;
    logic rx_line;

    uart_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk   (CLK),
        .rst_n (NRST),
        .div   (CFG_DIV),
        .tick  (tick)
    );

`ifdef UART_LOOPBACK_EN
    assign TX_DSER = CFG_LOOP ? 1'b1 : tx_ser;
    assign rx_line = CFG_LOOP ? tx_ser : RX_DSER;
`else
    assign TX_DSER = tx_ser;
    assign rx_line = RX_DSER;
`endif

    tx_state_e            tx_state, tx_state_nxt;
    logic [OS_W-1:0]      tx_os, tx_os_nxt;
    logic [3:0]           tx_bits, tx_bits_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par_en, tx_par_en_nxt;
    logic                 tx_par_val, tx_par_val_nxt;
    logic                 tx_stop2, tx_stop2_nxt;
    logic                 tx_ser_nxt, tx_busy, tx_busy_nxt, tx_done, tx_done_nxt;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_os == OS_LAST);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            tx_state   <= TX_IDLE;
            tx_os      <= '0;
            tx_bits    <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_val <= 1'b0;
            tx_stop2   <= 1'b0;
            tx_ser     <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_state   <= tx_state_nxt;
            tx_os      <= tx_os_nxt;
            tx_bits    <= tx_bits_nxt;
            tx_shift   <= tx_shift_nxt;
            tx_par_en  <= tx_par_en_nxt;
            tx_par_val <= tx_par_val_nxt;
            tx_stop2   <= tx_stop2_nxt;
            tx_ser     <= tx_ser_nxt;
            tx_busy    <= tx_busy_nxt;
            tx_done    <= tx_done_nxt;
        end
    end

    // A request in the TX_DONE cycle is refused so every frame is separated by one idle cycle.
    always_comb begin
        tx_state_nxt   = tx_state;
        tx_os_nxt      = tx_os;
        tx_bits_nxt    = tx_bits;
        tx_shift_nxt   = tx_shift;
        tx_par_en_nxt  = tx_par_en;
        tx_par_val_nxt = tx_par_val;
        tx_stop2_nxt   = tx_stop2;
        tx_ser_nxt     = tx_ser;
        tx_busy_nxt    = tx_busy;
        tx_done_nxt    = 1'b0;
        if (tx_state != TX_IDLE && tick) begin
            tx_os_nxt = tx_bit_end ? '0 : tx_os + OS_W'(1);
        end
        case (tx_state)
            TX_IDLE: begin
                if (TX_DRDY && !tx_done) begin
                    tx_state_nxt   = TX_START;
                    tx_os_nxt      = '0;
                    tx_shift_nxt   = TX_DI;
                    tx_par_en_nxt  = par_enabled(CFG_PAR);
                    tx_par_val_nxt = par_bit(CFG_PAR, ^TX_DI);
                    tx_stop2_nxt   = CFG_STOP2;
                    tx_ser_nxt     = 1'b0;
                    tx_busy_nxt    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_DATA;
                    tx_bits_nxt  = '0;
                    tx_ser_nxt   = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_bits == DATA_LAST) begin
                        tx_bits_nxt  = '0;
                        tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
                        tx_ser_nxt   = tx_par_en ? tx_par_val : 1'b1;
                    end else begin
                        tx_bits_nxt = tx_bits + 4'd1;
                        tx_ser_nxt  = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_STOP;
                    tx_bits_nxt  = '0;
                    tx_ser_nxt   = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop2 && tx_bits == 4'd0) begin
                        tx_bits_nxt = 4'd1;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                        tx_busy_nxt  = 1'b0;
                        tx_done_nxt  = 1'b1;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    assign TX_BUSY = tx_busy;
    assign TX_DONE = tx_done;

    logic [1:0]           rx_sync;
    logic                 rx_s;
    rx_state_e            rx_state, rx_state_nxt;
    logic [OS_W-1:0]      rx_os, rx_os_nxt;
    logic [3:0]           rx_bits, rx_bits_nxt;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic [1:0]           rx_par_mode, rx_par_mode_nxt;
    logic                 rx_par_rx, rx_par_rx_nxt;
    logic [DATA_BITS-1:0] rx_do, rx_do_nxt;
    logic                 rx_drdy, rx_drdy_nxt, rx_perr, rx_perr_nxt, rx_ferr, rx_ferr_nxt;
    logic                 rx_sample;

    assign rx_s      = rx_sync[1];
    assign rx_sample = tick && (rx_os == OS_LAST);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rx_sync     <= 2'b11;
            rx_state    <= RX_IDLE;
            rx_os       <= '0;
            rx_bits     <= '0;
            rx_shift    <= '0;
            rx_par_mode <= PAR_NONE;
            rx_par_rx   <= 1'b0;
            rx_do       <= '0;
            rx_drdy     <= 1'b0;
            rx_perr     <= 1'b0;
            rx_ferr     <= 1'b0;
        end else begin
            rx_sync     <= {rx_sync[0], rx_line};
            rx_state    <= rx_state_nxt;
            rx_os       <= rx_os_nxt;
            rx_bits     <= rx_bits_nxt;
            rx_shift    <= rx_shift_nxt;
            rx_par_mode <= rx_par_mode_nxt;
            rx_par_rx   <= rx_par_rx_nxt;
            rx_do       <= rx_do_nxt;
            rx_drdy     <= rx_drdy_nxt;
            rx_perr     <= rx_perr_nxt;
            rx_ferr     <= rx_ferr_nxt;
        end
    end

    // Any low stop bit parks in RX_BREAK so a held-low line cannot look like a new start edge.
    always_comb begin
        rx_state_nxt    = rx_state;
        rx_os_nxt       = rx_os;
        rx_bits_nxt     = rx_bits;
        rx_shift_nxt    = rx_shift;
        rx_par_mode_nxt = rx_par_mode;
        rx_par_rx_nxt   = rx_par_rx;
        rx_do_nxt       = rx_do;
        rx_perr_nxt     = rx_perr;
        rx_ferr_nxt     = rx_ferr;
        rx_drdy_nxt     = 1'b0;
        if ((rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP) && tick) begin
            rx_os_nxt = rx_sample ? '0 : rx_os + OS_W'(1);
        end
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt    = RX_START;
                    rx_os_nxt       = '0;
                    rx_par_mode_nxt = CFG_PAR;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_os == MID_LAST) begin
                        rx_os_nxt    = '0;
                        rx_bits_nxt  = '0;
                        rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_os_nxt = rx_os + OS_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_bits == DATA_LAST) begin
                        rx_state_nxt = par_enabled(rx_par_mode) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bits_nxt = rx_bits + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_rx_nxt = rx_s;
                    rx_state_nxt  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_do_nxt    = rx_shift;
                    rx_drdy_nxt  = 1'b1;
                    rx_ferr_nxt  = !rx_s;
                    rx_perr_nxt  = par_enabled(rx_par_mode) &&
                                   (rx_par_rx != par_bit(rx_par_mode, ^rx_shift));
                    rx_state_nxt = rx_s ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign RX_DO   = rx_do;
    assign RX_DRDY = rx_drdy;
    assign RX_PERR = rx_perr;
    assign RX_FERR = rx_ferr;

endmodule
